aoi_sweep: RTL
==============

# aoi_sweep

- Parametrised successor to the fixed 4-input AOI bench stimulus.
- Synthesizable sequencer that sweeps an N-input AND-OR-INVERT gate through every pattern of a selectable sequence (binary, Gray, walking-one), holding each pattern for a programmable number of cycles.
- Registers the gate response and flags valid outputs, so lab boards and higher-level checkers get a cycle-accurate, self-timed truth-table run instead of a free-running delay-based toggle.

## Interface
Parameters:
- N_IN, 4: number of AOI inputs; even, 2..8; inputs are grouped in adjacent pairs.
- DWELL, 2: cycles each pattern is held; 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin sweep; sampled only in IDLE.
- abort  in  1  synchronous stop; returns to IDLE.
- mode  in  2  sequence select, latched at start: 00 binary, 01 Gray, 10 walking-one, 11 treated as binary.
- stim  out  N_IN  current pattern driven to the gate.
- and_terms  out  N_IN/2  registered pair products; term j = stim[2j] & stim[2j+1].
- aoi_out  out  1  registered ~|and_terms.
- valid  out  1  and_terms/aoi_out correspond to a swept pattern.
- pattern_idx  out  N_IN  index of the pattern currently on stim.
- busy  out  1  high in RUN.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - stim, pattern_idx and the dwell counter are 0.
  - start=1 → RUN, latch mode, idx=0, dcnt=0, stim=encode(0).
- RUN:
  - dcnt counts 0..DWELL-1.
  - At dcnt=DWELL-1 with idx<LAST: idx+1, dcnt=0, stim=encode(idx+1).
  - At dcnt=DWELL-1 with idx=LAST: go to DONE, stim held.
- DONE: lasts one cycle, done=1, then IDLE with stim=0.
- LAST is 2^N_IN-1 for binary/Gray and N_IN-1 for walking-one.
- encode(i):
  - binary: i.
  - Gray: i ^ (i>>1).
  - walking-one: 1<<i.
- abort:
  - Any state → IDLE on the next edge; stim and idx cleared; no done pulse.
  - Abort has priority over start and over RUN advance.
- start while busy or in DONE is ignored.
- Output stage: and_terms and aoi_out are registered from stim. valid = registered (state==RUN).
- Reset values: stim=0, pattern_idx=0, and_terms=0, aoi_out=1 (response to the all-zero pattern), valid=0, busy=0, done=0, state IDLE.
- Reset mid-sweep discards all progress immediately (asynchronous); the next sweep restarts from idx 0.

## Timing
- start sampled at edge k: from edge k stim=encode(0) and busy=1; from edge k+1 valid=1 and aoi_out reflects pattern 0.
- Response latency is exactly 1 cycle from stim.
- RUN length is (LAST+1)*DWELL cycles.
- DONE follows; done=1 coincides with the final valid cycle (last pattern's response).
- valid falls the cycle after DONE.
- abort at edge m: busy=0 and stim=0 from edge m; valid=0 from edge m+1.
- Back-to-back: start may be asserted in the IDLE cycle immediately after DONE.

## Structure
- Package aoi_pkg:
  - Mode constants MODE_BIN, MODE_GRAY, MODE_WALK.
  - State encoding for IDLE/RUN/DONE.
  - Pattern-encode function shared with the bench reference model.
- Sub-module aoi_n (parameter N_IN): purely combinational pair-grouped AND-OR-INVERT producing and_terms and the inverted OR. aoi_sweep instantiates it on stim and registers its outputs.
- Sequencer, dwell counter and FSM live in aoi_sweep.

## Test plan
All cases use N_IN=4, DWELL=2 unless stated.
- Binary sweep, mode=00:
  - stim walks 0000..1111, each held 2 cycles; busy high 32 cycles; one done pulse.
  - aoi_out=1 for exactly 9 patterns (18 valid cycles), e.g. 0011 gives and_terms=01 and aoi_out=0.
- Gray sweep, mode=01: stim order 0000, 0001, 0011, 0010, 0110, …, 1000; each step flips exactly one bit; aoi_out matches the reference model per valid cycle.
- Walking-one, mode=10, DWELL=1:
  - stim = 0001, 0010, 0100, 1000; busy 4 cycles.
  - aoi_out=1 on all 4 valid cycles; done on the 4th valid cycle.
- Abort at pattern idx=5: IDLE next edge, stim=0000, no done pulse. A new start with mode=11 runs a full binary sweep.
- rst_n low for 1 cycle mid-RUN: all outputs at reset values immediately (aoi_out=1, valid=0). start pulses while busy=1 produce no restart or extra done.

Source files
------------

// File: rtl/aoi_pkg.sv
// aoi_pkg: mode codes, FSM states and pattern helpers shared by the sweeper and its bench
package aoi_pkg;
  localparam logic [1:0] MODE_BIN  = 2'b00;
  localparam logic [1:0] MODE_GRAY = 2'b01;
  localparam logic [1:0] MODE_WALK = 2'b10;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  // Patterns are at most 8 bits wide; callers truncate to their own N_IN.
  function automatic logic [7:0] encode(input logic [1:0] mode, input logic [7:0] i);
    return mode == MODE_GRAY ? i ^ (i >> 1) : mode == MODE_WALK ? 8'd1 << i[2:0] : i;
  endfunction
  function automatic logic [7:0] last_idx(input logic [1:0] mode, input int n);
    return mode == MODE_WALK ? 8'(n - 1) : 8'((1 << n) - 1);
  endfunction
endpackage

// File: rtl/aoi_sweep_if.sv
// aoi_sweep_if: control and result bundle of the AOI sweeper
//   start/abort/mode drive the sweep; stim, and_terms, aoi_out, valid,
//   pattern_idx, busy and done report it. master = controller, slave = sweeper.
interface aoi_sweep_if #(parameter int N_IN = 4);
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [N_IN-1:0]   stim;
  logic [N_IN/2-1:0] and_terms;
  logic              aoi_out;
  logic              valid;
  logic [N_IN-1:0]   pattern_idx;
  logic              busy;
  logic              done;
  modport master (output start, abort, mode,
                  input stim, and_terms, aoi_out, valid, pattern_idx, busy, done);
  modport slave  (input start, abort, mode,
                  output stim, and_terms, aoi_out, valid, pattern_idx, busy, done);
endinterface

// File: rtl/aoi_n.sv
// aoi_n: combinational pair-grouped AND-OR-INVERT gate
//   a: N_IN inputs; and_terms[j] = a[2j] & a[2j+1]; y = ~|and_terms
module aoi_n #(parameter int N_IN = 4) (
  input  logic [N_IN-1:0]   a,
  output logic [N_IN/2-1:0] and_terms,
  output logic              y
);
  for (genvar j = 0; j < N_IN / 2; j++) begin : g_pair
    assign and_terms[j] = a[2*j] & a[2*j+1];
  end
  assign y = ~|and_terms;
endmodule

// File: rtl/aoi_sweep.sv
// aoi_sweep: sequences an N-input AOI gate through binary, Gray or walking-one patterns
//   clk, rst_n (async active-low); bus: start/abort/mode in, stim, registered
//   and_terms/aoi_out with valid, pattern_idx, busy and a one-cycle done pulse out.
module aoi_sweep
  import aoi_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int DWELL = 2
) (
  input logic      clk,
  input logic      rst_n,
  aoi_sweep_if.slave bus
);
  state_e            state, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [N_IN-1:0]   idx, idx_d, stim, stim_d;
  logic [7:0]        dcnt, dcnt_d;
  logic [N_IN/2-1:0] and_c, and_q;
  logic              aoi_c, aoi_q, valid_q, dwell_end, at_last;
  assign dwell_end = dcnt == 8'(DWELL - 1);
  assign at_last   = idx == N_IN'(last_idx(mode_q, N_IN));
  always_comb begin
    state_d = state;
    mode_d  = mode_q;
    idx_d   = idx;
    dcnt_d  = dcnt;
    if (bus.abort) begin
      state_d = IDLE;
      idx_d   = '0;
      dcnt_d  = '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          state_d = RUN;
          mode_d  = bus.mode;
        end
        RUN: if (!dwell_end) dcnt_d = dcnt + 8'd1;
          else if (!at_last) begin
            idx_d  = idx + N_IN'(1);
            dcnt_d = '0;
          end else state_d = DONE;
        DONE: begin
          state_d = IDLE;
          idx_d   = '0;
          dcnt_d  = '0;
        end
        default: state_d = IDLE;
      endcase
    end
    // DONE keeps idx, so the last pattern stays on stim for its response cycle.
    stim_d = state_d == IDLE ? '0 : N_IN'(encode(mode_d, 8'(idx_d)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= MODE_BIN;
      idx     <= '0;
      dcnt    <= '0;
      stim    <= '0;
      and_q   <= '0;
      aoi_q   <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state   <= state_d;
      mode_q  <= mode_d;
      idx     <= idx_d;
      dcnt    <= dcnt_d;
      stim    <= stim_d;
      and_q   <= and_c;
      aoi_q   <= aoi_c;
      valid_q <= state == RUN;
    end
  end
  aoi_n #(.N_IN(N_IN)) u_aoi (.a(stim), .and_terms(and_c), .y(aoi_c));
  assign bus.stim        = stim;
  assign bus.and_terms   = and_q;
  assign bus.aoi_out     = aoi_q;
  assign bus.valid       = valid_q;
  assign bus.pattern_idx = idx;
  assign bus.busy        = state == RUN;
  assign bus.done        = state == DONE;
endmodule
